// File: rtl/membus_arbiter.sv
// membus_arbiter: shares the single memory0 port between cpu0 (port 0) and the
// loader/DMA engine (port 1). One access at a time, round-robin on contention,
// each access sequenced IDLE -> ACCESS -> DONE. The console address is decoded
// so console writes never reach memory; out-of-range addresses return an error.
//
// Ports:
//   clock, reset            system clock, synchronous active-high reset
//   req/rw/size/addr/wdataN requester N access (held until doneN)
//   doneN, errN             one-cycle completion pulse, error flag (valid with done)
//   rdata                   shared read data, valid with done
//   m_en/m_rw/m_size/m_addr/m_wdata, m_rdata   memory0 port
//   io_we/io_size/io_data   console write strobe and payload
// All outputs are registered.
module membus_arbiter #(
  parameter int unsigned MEMSIZE = 'h80000,
  parameter int unsigned IOADDR  = 'h80000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req0,
  input  logic        req1,
  input  logic        rw0,
  input  logic        rw1,
  input  logic [1:0]  size0,
  input  logic [1:0]  size1,
  input  logic [31:0] addr0,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata0,
  input  logic [31:0] wdata1,
  output logic        done0,
  output logic        done1,
  output logic        err0,
  output logic        err1,
  output logic [31:0] rdata,
  output logic        m_en,
  output logic        m_rw,
  output logic [1:0]  m_size,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata,
  output logic        io_we,
  output logic [1:0]  io_size,
  output logic [31:0] io_data
);

  typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;
  typedef enum logic [1:0] {ClsMem, ClsIo, ClsBad} cls_e;

  state_e      state_q, state_d;
  cls_e        cls_q, cls_d;
  logic        owner_q, owner_d;
  logic        last_q, last_d;
  logic        rw_q, rw_d;
  logic        done0_q, done0_d, done1_q, done1_d;
  logic        err0_q, err0_d, err1_q, err1_d;
  logic [31:0] rdata_q, rdata_d;
  logic        m_en_q, m_en_d, m_rw_q, m_rw_d;
  logic [1:0]  m_size_q, m_size_d;
  logic [31:0] m_addr_q, m_addr_d, m_wdata_q, m_wdata_d;
  logic        io_we_q, io_we_d;
  logic [1:0]  io_size_q, io_size_d;
  logic [31:0] io_data_q, io_data_d;

  // Grant selection: a lone request wins; on a tie the port that did not go last wins.
  logic        grant_port;
  logic        sel_rw;
  logic [1:0]  sel_size;
  logic [31:0] sel_addr, sel_wdata;
  cls_e        sel_cls;

  function automatic cls_e classify(input logic [31:0] a);
    if (a <= MEMSIZE - 32'd4) return ClsMem;
    else if (a == IOADDR)     return ClsIo;
    else                      return ClsBad;
  endfunction

  always_comb begin
    grant_port = (req0 && req1) ? ~last_q : req1;
    sel_rw     = grant_port ? rw1    : rw0;
    sel_size   = grant_port ? size1  : size0;
    sel_addr   = grant_port ? addr1  : addr0;
    sel_wdata  = grant_port ? wdata1 : wdata0;
    sel_cls    = classify(sel_addr);
  end

  always_comb begin
    state_d   = state_q;
    cls_d     = cls_q;
    owner_d   = owner_q;
    last_d    = last_q;
    rw_d      = rw_q;
    done0_d   = 1'b0;
    done1_d   = 1'b0;
    err0_d    = 1'b0;
    err1_d    = 1'b0;
    rdata_d   = rdata_q;
    m_en_d    = 1'b0;
    m_rw_d    = m_rw_q;
    m_size_d  = m_size_q;
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;
    io_we_d   = 1'b0;
    io_size_d = io_size_q;
    io_data_d = io_data_q;

    case (state_q)
      StIdle: begin
        if (req0 || req1) begin
          owner_d = grant_port;
          last_d  = grant_port;
          rw_d    = sel_rw;
          cls_d   = sel_cls;
          state_d = StAccess;
          // Memory/console outputs are loaded here so they are live, registered,
          // during the ACCESS cycle. The memory fields only move for real accesses.
          if (sel_cls == ClsMem) begin
            m_en_d    = 1'b1;
            m_rw_d    = sel_rw;
            m_size_d  = sel_size;
            m_addr_d  = sel_addr;
            m_wdata_d = sel_wdata;
          end
          if (sel_cls == ClsIo && !sel_rw) begin
            io_we_d   = 1'b1;
            io_size_d = sel_size;
            io_data_d = sel_wdata;
          end
        end
      end
      StAccess: begin
        state_d = StDone;
        case (cls_q)
          ClsMem:  if (rw_q) rdata_d = m_rdata;
          ClsIo:   if (rw_q) rdata_d = '0;
          default: rdata_d = '0;
        endcase
        done0_d = ~owner_q;
        done1_d = owner_q;
        err0_d  = ~owner_q && (cls_q == ClsBad);
        err1_d  = owner_q && (cls_q == ClsBad);
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= StIdle;
      cls_q     <= ClsMem;
      owner_q   <= 1'b0;
      last_q    <= 1'b1;  // port 0 wins the first tie
      rw_q      <= 1'b0;
      done0_q   <= 1'b0;
      done1_q   <= 1'b0;
      err0_q    <= 1'b0;
      err1_q    <= 1'b0;
      rdata_q   <= '0;
      m_en_q    <= 1'b0;
      m_rw_q    <= 1'b0;
      m_size_q  <= '0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      io_we_q   <= 1'b0;
      io_size_q <= '0;
      io_data_q <= '0;
    end else begin
      state_q   <= state_d;
      cls_q     <= cls_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      rw_q      <= rw_d;
      done0_q   <= done0_d;
      done1_q   <= done1_d;
      err0_q    <= err0_d;
      err1_q    <= err1_d;
      rdata_q   <= rdata_d;
      m_en_q    <= m_en_d;
      m_rw_q    <= m_rw_d;
      m_size_q  <= m_size_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
      io_we_q   <= io_we_d;
      io_size_q <= io_size_d;
      io_data_q <= io_data_d;
    end
  end

  assign done0   = done0_q;
  assign done1   = done1_q;
  assign err0    = err0_q;
  assign err1    = err1_q;
  assign rdata   = rdata_q;
  assign m_en    = m_en_q;
  assign m_rw    = m_rw_q;
  assign m_size  = m_size_q;
  assign m_addr  = m_addr_q;
  assign m_wdata = m_wdata_q;
  assign io_we   = io_we_q;
  assign io_size = io_size_q;
  assign io_data = io_data_q;

endmodule
